uart_core: RTL and testbench



---
 rtl/uart_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_core.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a shared baud tick generator.
//   The transmitter sends DATA_BITS data bits LSB first, with optional even or odd
//   parity and 1 or 2 stop bits.
//   The receiver oversamples at 16x and samples each bit at mid-bit. It rejects
//   short start glitches and reports parity and framing errors.
//
// Ports:
//   clk, rst       system clock; asynchronous active-low reset
//   tx_data        word to send (DATA_BITS)
//   tx_valid       tx_data valid
//   tx_ready       transmitter idle, can accept tx_data
//   tx_done        one-cycle pulse as the transmitter returns to idle
//   tx             serial output, idle high
//   rx             serial input, asynchronous to clk
//   rx_data        last received word, held until the next delivery
//   rx_valid       one-cycle pulse, new word on rx_data
//   rx_parity_err  parity mismatch, qualified by rx_valid
//   rx_frame_err   first stop bit sampled low, qualified by rx_valid
//
// Handshake: tx_data is taken on a clk edge where tx_valid && tx_ready.
// tx_ready is high only while the transmitter is idle. tx_valid is ignored at
// all other times, so the sender holds tx_data/tx_valid until the transfer
// happens. The receive side has no backpressure: rx_valid is a single-cycle
// pulse.
module uart_core #(
    parameter int CLK_FREQ   = 1600000,
    parameter int BAUD_RATE  = 10000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int   DIV     = CLK_FREQ / (BAUD_RATE * 16);
    localparam int   DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Shared tick generator: one tick every DIV clocks; 16 ticks per bit.
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_bit_end;

    logic                 rx_s1_q, rx_s2_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]           rx_tick_q, rx_tick_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic                 rx_perr_int_q, rx_perr_int_d;
    logic                 rx_armed_q, rx_armed_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_sync, rx_mid;

    always_comb begin
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    // Transmitter. Each bit ends on the 16th tick after it began. Only the start
    // bit's length depends on the tick phase at acceptance.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        tx_bit_end = tick && (tx_tick_q == 4'd15);
        if (tx_state_q != TX_IDLE && tick) tx_tick_d = tx_tick_q + 4'd1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                    tx_tick_d  = 4'd0;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_d       = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = 4'd0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                    tx_bit_d = 4'd0;
                    if (PARITY_EN != 0) begin
                        tx_d       = tx_par_q;
                        tx_state_d = TX_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_d       = 1'b1;
                tx_bit_d   = 4'd0;
                tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Receiver. The bit phase restarts at the falling edge. The start bit is
    // checked 8 ticks in, at mid-bit. Every later sample is 16 ticks after the
    // previous one. After a frame error the receiver stays disarmed until the
    // line returns high, so a held-low line (break) delivers only one frame.
    always_comb begin
        rx_sync       = rx_s2_q;
        rx_mid        = tick && (rx_tick_q == 4'd15);
        rx_state_d    = rx_state_q;
        rx_shift_d    = rx_shift_q;
        rx_tick_d     = rx_tick_q;
        rx_bit_d      = rx_bit_q;
        rx_perr_int_d = rx_perr_int_q;
        rx_armed_d    = rx_armed_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_perr_d     = 1'b0;
        rx_ferr_d     = 1'b0;
        if (rx_state_q != RX_IDLE && tick) rx_tick_d = rx_tick_q + 4'd1;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_sync) rx_armed_d = 1'b1;
                if (!rx_sync && rx_armed_q) begin
                    rx_tick_d     = 4'd0;
                    rx_perr_int_d = 1'b0;
                    rx_state_d    = RX_START;
                end
            end
            RX_START: if (tick && rx_tick_q == 4'd7) begin
                if (rx_sync) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_tick_d  = 4'd0;
                    rx_bit_d   = 4'd0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: if (rx_mid) begin
                rx_shift_d = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == 4'(DATA_BITS - 1))
                    rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                else
                    rx_bit_d = rx_bit_q + 4'd1;
            end
            RX_PARITY: if (rx_mid) begin
                rx_perr_int_d = (rx_sync != ((^rx_shift_q) ^ PAR_ODD));
                rx_state_d    = RX_STOP;
            end
            RX_STOP: if (rx_mid) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                rx_perr_d  = rx_perr_int_q;
                rx_ferr_d  = !rx_sync;
                if (!rx_sync) rx_armed_d = 1'b0;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            tx_state_q    <= TX_IDLE;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_tick_q     <= 4'd0;
            tx_bit_q      <= 4'd0;
            tx_q          <= 1'b1;
            tx_done_q     <= 1'b0;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_shift_q    <= '0;
            rx_tick_q     <= 4'd0;
            rx_bit_q      <= 4'd0;
            rx_perr_int_q <= 1'b0;
            rx_armed_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_tick_q     <= tx_tick_d;
            tx_bit_q      <= tx_bit_d;
            tx_q          <= tx_d;
            tx_done_q     <= tx_done_d;
            rx_s1_q       <= rx;
            rx_s2_q       <= rx_s1_q;
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_perr_int_q <= rx_perr_int_d;
            rx_armed_q    <= rx_armed_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
        end
    end

    assign tx_ready      = (tx_state_q == TX_IDLE);
    assign tx_done       = tx_done_q;
    assign tx            = tx_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
module tb_uart_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // dut_a: 8N1, rx driven by the bench
    logic [7:0] tx_data_a = '0;
    logic       tx_valid_a = 1'b0, rx_a = 1'b1;
    logic       tx_ready_a, tx_done_a, tx_a, rx_valid_a, rx_perr_a, rx_ferr_a;
    logic [7:0] rx_data_a;
    // dut_b: 8 data, odd parity, 2 stop; rx is loopback or bench-driven
    logic [7:0] tx_data_b = '0;
    logic       tx_valid_b = 1'b0, rx_b_drv = 1'b1, loop_b = 1'b1;
    logic       tx_ready_b, tx_done_b, tx_b, rx_b, rx_valid_b, rx_perr_b, rx_ferr_b;
    logic [7:0] rx_data_b;
    // dut_c: 5N1 loopback
    logic [4:0] tx_data_c = '0;
    logic       tx_valid_c = 1'b0;
    logic       tx_ready_c, tx_done_c, tx_c, rx_valid_c, rx_perr_c, rx_ferr_c;
    logic [4:0] rx_data_c;

    assign rx_b = loop_b ? tx_b : rx_b_drv;

    uart_core dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .tx_done(tx_done_a), .tx(tx_a), .rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_parity_err(rx_perr_a),
        .rx_frame_err(rx_ferr_a)
    );
    uart_core #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx_done(tx_done_b), .tx(tx_b), .rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_parity_err(rx_perr_b),
        .rx_frame_err(rx_ferr_b)
    );
    uart_core #(.DATA_BITS(5)) dut_c (
        .clk(clk), .rst(rst), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
        .tx_ready(tx_ready_c), .tx_done(tx_done_c), .tx(tx_c), .rx(tx_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_parity_err(rx_perr_c),
        .rx_frame_err(rx_ferr_c)
    );

    // Monitor: records deliveries and tx_done events, sampled on the falling edge.
    int         rxa_cnt = 0, rxc_cnt = 0, txd_a_cnt = 0, txd_c_cnt = 0, txd_b_cnt = 0;
    int         txd_a_cyc = 0, txd_c_cyc = 0, txd_bad = 0, leak = 0;
    logic [7:0] rxa_data = '0;
    logic       rxa_perr = 1'b0, rxa_ferr = 1'b0, rxc_perr = 1'b0, rxc_ferr = 1'b0;
    logic [4:0] rxc_data = '0;
    logic [9:0] got_q[$];   // {parity_err, frame_err, data} from dut_b
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (rx_valid_a) begin
            rxa_cnt++; rxa_data = rx_data_a; rxa_perr = rx_perr_a; rxa_ferr = rx_ferr_a;
        end
        if (rx_valid_b) got_q.push_back({rx_perr_b, rx_ferr_b, rx_data_b});
        if (rx_valid_c) begin
            rxc_cnt++; rxc_data = rx_data_c; rxc_perr = rx_perr_c; rxc_ferr = rx_ferr_c;
        end
        if (tx_done_a) begin txd_a_cnt++; txd_a_cyc = cyc; if (!tx_ready_a) txd_bad++; end
        if (tx_done_b) begin txd_b_cnt++; if (!tx_ready_b) txd_bad++; end
        if (tx_done_c) begin txd_c_cnt++; txd_c_cyc = cyc; if (!tx_ready_c) txd_bad++; end
        if (!rx_valid_a && (rx_perr_a || rx_ferr_a)) leak++;
        if (!rx_valid_b && (rx_perr_b || rx_ferr_b)) leak++;
        if (!rx_valid_c && (rx_perr_c || rx_ferr_c)) leak++;
    end

    function automatic logic get_tx(input int which);
        case (which)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v; else rx_b_drv = v;
    endtask

    // Driver: one frame on a bench-driven rx line, 160 clks per bit.
    task automatic drive_rx(input int which, input logic [8:0] data, input int nbits,
                            input int has_par, input logic pbit, input logic stop1,
                            input int nstop);
        set_rx(which, 1'b0); repeat (160) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]); repeat (160) @(negedge clk);
        end
        if (has_par != 0) begin set_rx(which, pbit); repeat (160) @(negedge clk); end
        set_rx(which, stop1); repeat (160) @(negedge clk);
        for (int s = 1; s < nstop; s++) begin set_rx(which, 1'b1); repeat (160) @(negedge clk); end
        set_rx(which, 1'b1);
    endtask

    // Line decoder: waits for a start edge, then samples mid-bit using bench timing.
    task automatic decode_tx(input int which, input int nbits, input int has_par, input int nstop,
                             output logic [8:0] data, output logic pbit, output logic [1:0] stops,
                             output int fall_cyc, output bit ok);
        int n;
        ok = 1'b0; data = '0; pbit = 1'b0; stops = '0; fall_cyc = 0; n = 0;
        while (get_tx(which) !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) return;
        fall_cyc = cyc;
        repeat (80) @(negedge clk);
        if (get_tx(which) !== 1'b0) return;
        for (int i = 0; i < nbits; i++) begin repeat (160) @(negedge clk); data[i] = get_tx(which); end
        if (has_par != 0) begin repeat (160) @(negedge clk); pbit = get_tx(which); end
        for (int s = 0; s < nstop; s++) begin repeat (160) @(negedge clk); stops[s] = get_tx(which); end
        ok = 1'b1;
    endtask

    int run_len[8];
    int run_fall = 0;
    task automatic measure_runs(input int which, input int nruns);
        int n;
        logic lvl;
        for (int r = 0; r < 8; r++) run_len[r] = 0;
        n = 0;
        while (get_tx(which) !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        run_fall = cyc;
        lvl = 1'b0;
        for (int r = 0; r < nruns; r++) begin
            n = 0;
            while (get_tx(which) === lvl && n < 5000) begin @(negedge clk); n++; end
            run_len[r] = n;
            lvl = ~lvl;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (tx_a !== 1'b1) $display("FAIL reset_tx_in_reset: got %b want 1", tx_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_a !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx_a); else n_pass++;
        n_checks++; if (tx_ready_a !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready_a); else n_pass++;
        n_checks++; if (tx_done_a !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", tx_done_a); else n_pass++;
        n_checks++; if (rx_data_a !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data_a); else n_pass++;
        n_checks++; if ({rx_valid_a, rx_perr_a, rx_ferr_a} !== 3'b000)
            $display("FAIL reset_rx_flags: got %b want 000", {rx_valid_a, rx_perr_a, rx_ferr_a}); else n_pass++;
        n_checks++; if ({tx_b, tx_ready_b, tx_c, tx_ready_c} !== 4'b1111)
            $display("FAIL reset_other_tx: got %b want 1111", {tx_b, tx_ready_b, tx_c, tx_ready_c}); else n_pass++;
        repeat (2000) @(negedge clk);
        n_checks++; if (rxa_cnt + rxc_cnt + got_q.size() != 0)
            $display("FAIL idle_no_rx_valid: got %0d deliveries want 0", rxa_cnt + rxc_cnt + got_q.size()); else n_pass++;
    endtask

    task automatic test_tx_8n1();
        logic [8:0] d; logic pb; logic [1:0] st; int fc; bit ok;
        int exp_runs[7];
        exp_runs = '{0, 160, 160, 160, 320, 160, 160};
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        n_checks++; if (tx_ready_a !== 1'b1) $display("FAIL tx_ready_before: got %b want 1", tx_ready_a); else n_pass++;
        fork
            begin
                @(negedge clk); tx_valid_a = 1'b0;
                n_checks++; if ({tx_ready_a, tx_a} !== 2'b00)
                    $display("FAIL tx_accept: ready,tx got %b want 00", {tx_ready_a, tx_a}); else n_pass++;
            end
            decode_tx(0, 8, 0, 1, d, pb, st, fc, ok);
            measure_runs(0, 7);
        join
        repeat (200) @(negedge clk);
        n_checks++; if (!ok || d[7:0] !== 8'hA5) $display("FAIL tx_a5_data: got %h ok=%0d want a5", d[7:0], ok); else n_pass++;
        n_checks++; if (st[0] !== 1'b1) $display("FAIL tx_a5_stop: got %b want 1", st[0]); else n_pass++;
        n_checks++; if (run_len[0] < 151 || run_len[0] > 160)
            $display("FAIL tx_start_len: got %0d want 151..160", run_len[0]); else n_pass++;
        for (int r = 1; r < 7; r++) begin
            n_checks++; if (run_len[r] != exp_runs[r])
                $display("FAIL tx_run%0d: got %0d want %0d", r, run_len[r], exp_runs[r]); else n_pass++;
        end
        n_checks++; if (txd_a_cnt != 1) $display("FAIL tx_done_count: got %0d want 1", txd_a_cnt); else n_pass++;
        n_checks++; if (txd_a_cyc - run_fall != run_len[0] + 1440)
            $display("FAIL tx_done_time: got %0d want %0d", txd_a_cyc - run_fall, run_len[0] + 1440); else n_pass++;
        n_checks++; if (txd_bad != 0) $display("FAIL tx_ready_with_done: got %0d bad want 0", txd_bad); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] vals[3];
        logic [7:0] dd[3]; logic dp[3]; logic [1:0] ds[3]; int df[3]; bit dok[3];
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;
        got_q.delete(); exp_q.delete(); loop_b = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back({2'b00, vals[k]});
        fork
            begin
                int n;
                for (int k = 0; k < 3; k++) begin
                    tx_data_b = vals[k]; tx_valid_b = 1'b1; n = 0;
                    while (!tx_ready_b && n < 5000) begin @(negedge clk); n++; end
                    @(negedge clk);
                end
                tx_valid_b = 1'b0;
            end
            begin
                logic [8:0] d; logic pb; logic [1:0] st; int fc; bit ok;
                for (int k = 0; k < 3; k++) begin
                    decode_tx(1, 8, 1, 2, d, pb, st, fc, ok);
                    dd[k] = d[7:0]; dp[k] = pb; ds[k] = st; df[k] = fc; dok[k] = ok;
                end
            end
        join
        repeat (300) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (!dok[k] || dd[k] !== vals[k])
                $display("FAIL lb_line_data%0d: got %h ok=%0d want %h", k, dd[k], dok[k], vals[k]); else n_pass++;
            n_checks++; if (dp[k] !== 1'b1) $display("FAIL lb_parity%0d: got %b want 1", k, dp[k]); else n_pass++;
            n_checks++; if (ds[k] !== 2'b11) $display("FAIL lb_stops%0d: got %b want 11", k, ds[k]); else n_pass++;
        end
        for (int k = 1; k < 3; k++) begin
            n_checks++; if (df[k] - df[k-1] < 1911 || df[k] - df[k-1] > 1921)
                $display("FAIL lb_gap%0d: got %0d want 1911..1921", k, df[k] - df[k-1]); else n_pass++;
        end
        n_checks++; if (got_q.size() != 3) $display("FAIL lb_rx_count: got %0d want 3", got_q.size()); else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [9:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL lb_rx_word: got %h want %h", g, e); else n_pass++;
        end
    endtask

    task automatic test_rx_errors();
        got_q.delete(); exp_q.delete(); loop_b = 1'b0; rx_b_drv = 1'b1;
        repeat (20) @(negedge clk);
        // 0x55: four ones, so the correct odd parity bit is 1; send 0
        exp_q.push_back({2'b10, 8'h55});
        drive_rx(1, 9'h055, 8, 1, 1'b0, 1'b1, 2);
        repeat (300) @(negedge clk);
        // 0x12: two ones, odd parity bit 1 (correct); first stop bit 0
        exp_q.push_back({2'b01, 8'h12});
        drive_rx(1, 9'h012, 8, 1, 1'b1, 1'b0, 2);
        repeat (300) @(negedge clk);
        n_checks++; if (got_q.size() != 2) $display("FAIL err_rx_count: got %0d want 2", got_q.size()); else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [9:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) $display("FAIL err_rx_word: got %h want %h", g, e); else n_pass++;
        end
        loop_b = 1'b1;
    endtask

    task automatic test_glitch_break();
        int base;
        base = rxa_cnt;
        rx_a = 1'b0; repeat (40) @(negedge clk); rx_a = 1'b1;
        repeat (400) @(negedge clk);
        n_checks++; if (rxa_cnt != base) $display("FAIL glitch_rx_valid: got %0d want 0", rxa_cnt - base); else n_pass++;
        drive_rx(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1);
        repeat (300) @(negedge clk);
        n_checks++; if (rxa_cnt != base + 1 || {rxa_perr, rxa_ferr, rxa_data} !== {2'b00, 8'h5A})
            $display("FAIL rx_5a: got cnt %0d word %h want 1 05a", rxa_cnt - base, {rxa_perr, rxa_ferr, rxa_data}); else n_pass++;
        rx_a = 1'b0; repeat (3000) @(negedge clk);
        n_checks++; if (rxa_cnt != base + 2 || {rxa_ferr, rxa_data} !== 9'h100)
            $display("FAIL break_frame: got cnt %0d ferr,data %h want 2 100", rxa_cnt - base, {rxa_ferr, rxa_data}); else n_pass++;
        rx_a = 1'b1; repeat (300) @(negedge clk);
        drive_rx(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 1);
        repeat (300) @(negedge clk);
        n_checks++; if (rxa_cnt != base + 3 || {rxa_ferr, rxa_data} !== 9'h0C3)
            $display("FAIL rearm_c3: got cnt %0d ferr,data %h want 3 0c3", rxa_cnt - base, {rxa_ferr, rxa_data}); else n_pass++;
        n_checks++; if (leak != 0) $display("FAIL err_flags_idle: got %0d cycles want 0", leak); else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic [8:0] d; logic pb; logic [1:0] st; int fc; bit ok; int n;
        tx_data_a = 8'h00; tx_valid_a = 1'b1;
        @(negedge clk); tx_valid_a = 1'b0;
        n = 0;
        while (tx_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (240) @(negedge clk);
        n_checks++; if (tx_a !== 1'b0) $display("FAIL midtx_low: got %b want 0", tx_a); else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++; if ({tx_a, tx_ready_a} !== 2'b11) $display("FAIL midtx_reset: tx,ready got %b want 11", {tx_a, tx_ready_a}); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        tx_data_a = 8'h81; tx_valid_a = 1'b1;
        fork
            begin @(negedge clk); tx_valid_a = 1'b0; end
            decode_tx(0, 8, 0, 1, d, pb, st, fc, ok);
        join
        n_checks++; if (!ok || {st[0], d[7:0]} !== 9'h181)
            $display("FAIL after_reset_81: got stop,data %h ok=%0d want 181", {st[0], d[7:0]}, ok); else n_pass++;
        repeat (200) @(negedge clk);
    endtask

    task automatic test_data5();
        int base_d;
        base_d = txd_c_cnt;
        tx_data_c = 5'h1F; tx_valid_c = 1'b1;
        fork
            begin @(negedge clk); tx_valid_c = 1'b0; end
            measure_runs(2, 1);
        join
        repeat (1300) @(negedge clk);
        n_checks++; if (run_len[0] < 151 || run_len[0] > 160)
            $display("FAIL d5_start_len: got %0d want 151..160", run_len[0]); else n_pass++;
        n_checks++; if (txd_c_cnt != base_d + 1) $display("FAIL d5_done_count: got %0d want 1", txd_c_cnt - base_d); else n_pass++;
        n_checks++; if (txd_c_cyc - run_fall != run_len[0] + 960)
            $display("FAIL d5_frame_len: got %0d want %0d", txd_c_cyc - run_fall, run_len[0] + 960); else n_pass++;
        n_checks++; if (rxc_cnt != 1 || {rxc_perr, rxc_ferr, rxc_data} !== 7'h1F)
            $display("FAIL d5_rx: got cnt %0d word %h want 1 1f", rxc_cnt, {rxc_perr, rxc_ferr, rxc_data}); else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback();
        test_rx_errors();
        test_glitch_break();
        test_reset_mid_tx();
        test_data5();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
